// File: rtl/word_splitter_if.sv
// rtl/word_splitter_if.sv - word/strobe input and byte/handshake output bundle for word_splitter
interface word_splitter_if #(
  parameter int M     = 16,
  parameter int N     = 8,
  parameter int LVL_W = 6
);
  logic             en;
  logic [M-1:0]     word_in;
  logic             ready_in;
  logic             get;
  logic             msb_first;
  logic             clr_err;
  logic [N-1:0]     byte_out;
  logic             ready;
  logic [LVL_W-1:0] byte_level;
  logic             errore_overflow;
  logic             errore_underflow;

  modport master (
    output en, word_in, ready_in, get, msb_first, clr_err,
    input  byte_out, ready, byte_level, errore_overflow, errore_underflow
  );

  modport slave (
    input  en, word_in, ready_in, get, msb_first, clr_err,
    output byte_out, ready, byte_level, errore_overflow, errore_underflow
  );
endinterface

// File: rtl/word_splitter.sv
// rtl/word_splitter.sv - strobe-captured M-bit word FIFO emitted as N-bit slices on get/ready
module word_splitter #(
  parameter int M     = 16,
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int LVL_W = 6
) (
  input logic              rdclk,
  input logic              nreset,
  word_splitter_if.slave   bus
);
  localparam int K     = M / N;
  localparam int SL_W  = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [M-1:0]       mem_q [DEPTH];
  logic               s1_q, s2_q, s3_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SL_W-1:0]    slice_q, slice_d;
  logic               order_q, order_d;
  logic [N-1:0]       byte_q, byte_d;
  logic               ready_q, ready_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  logic               push_evt, full, grant, last, pop, push_ok, ovf_set, unf_set, msb_eff;
  logic [M-1:0]       head, shifted;
  logic [N-1:0]       slice_byte;
  int                 sh;

  // Strobe synchroniser plus one extra stage for rising-edge detection; free-running regardless of en
  always_ff @(posedge rdclk or negedge nreset) begin
    if (!nreset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.ready_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign push_evt = s2_q & ~s3_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign grant    = bus.en & ~ready_q & bus.get & (level_q != '0);
  assign last     = (slice_q == SL_W'(K - 1));
  assign pop      = grant & last;
  assign push_ok  = bus.en & push_evt & (~full | pop);
  assign ovf_set  = bus.en & push_evt & full & ~pop;
  assign unf_set  = bus.en & ~ready_q & bus.get & (level_q == '0);
  // Order is sampled live on the first slice and frozen for the rest of the word
  assign msb_eff  = (slice_q == '0) ? bus.msb_first : order_q;
  assign head     = mem_q[rd_ptr_q];

  // Select the current slice of the head word by shifting it down to bit 0
  always_comb begin
    sh = msb_eff ? (K - 1 - int'(slice_q)) * N : int'(slice_q) * N;
    shifted    = head >> sh;
    slice_byte = shifted[N-1:0];
  end

  // Next-state for pointers, count, slice index, output byte, handshake and sticky flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slice_d  = slice_q;
    order_d  = order_q;
    byte_d   = byte_q;
    ready_d  = ready_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    if (grant) begin
      byte_d  = slice_byte;
      slice_d = last ? '0 : slice_q + 1'b1;
      if (slice_q == '0) order_d = bus.msb_first;
    end
    if (bus.en) ready_d = grant;
    level_d = LVL_W'(int'(count_d) * K - int'(slice_d));
    ovf_d = ovf_set ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
    unf_d = unf_set ? 1'b1 : (bus.clr_err ? 1'b0 : unf_q);
  end

  // Control and output registers
  always_ff @(posedge rdclk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slice_q  <= '0;
      order_q  <= 1'b0;
      byte_q   <= '0;
      ready_q  <= 1'b0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slice_q  <= slice_d;
      order_q  <= order_d;
      byte_q   <= byte_d;
      ready_q  <= ready_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Word storage; contents survive reset since the pointers define validity
  always_ff @(posedge rdclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.word_in;
  end

  assign bus.byte_out         = byte_q;
  assign bus.ready            = ready_q;
  assign bus.byte_level       = level_q;
  assign bus.errore_overflow  = ovf_q;
  assign bus.errore_underflow = unf_q;
endmodule

// File: tb/tb_word_splitter.sv
// tb/tb_word_splitter.sv - directed table and sequence checks for word_splitter
module tb_word_splitter;
  logic rdclk = 1'b0;
  logic nreset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 rdclk = ~rdclk;

  word_splitter_if #(.M(16), .N(8), .LVL_W(6)) b1 ();
  word_splitter_if #(.M(32), .N(8), .LVL_W(5)) b2 ();

  word_splitter #(.M(16), .N(8), .DEPTH(16), .PTR_W(4), .LVL_W(6)) dut1 (
    .rdclk(rdclk), .nreset(nreset), .bus(b1)
  );
  word_splitter #(.M(32), .N(8), .DEPTH(4), .PTR_W(2), .LVL_W(5)) dut2 (
    .rdclk(rdclk), .nreset(nreset), .bus(b2)
  );

  typedef struct packed {
    logic        en;
    logic        rin;
    logic        get;
    logic        msb;
    logic        clr;
    logic        e_rdy;
    logic [7:0]  e_byte;
    logic [5:0]  e_lvl;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic strobe1(input logic [15:0] w);
    b1.word_in = w;
    b1.ready_in = 1'b1;
    tick();
    tick();
    b1.ready_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic get_byte1(input string name, input logic [7:0] exp);
    b1.get = 1'b1;
    tick();
    chk({name, "_ready"}, 32'(b1.ready), 32'd1);
    chk({name, "_byte"}, 32'(b1.byte_out), 32'(exp));
    b1.get = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [31:0] w32;
    // en rin get msb clr | rdy byte lvl ovf unf
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd2, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 6'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 6'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 6'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 6'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 6'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 6'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 6'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 6'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 6'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 6'd1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 6'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 6'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 6'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 6'd0, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 6'd0, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 6'd0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 6'd0, 1'b0, 1'b0};

    b1.en = 1'b1; b1.word_in = '0; b1.ready_in = 1'b0; b1.get = 1'b0;
    b1.msb_first = 1'b1; b1.clr_err = 1'b0;
    b2.en = 1'b1; b2.word_in = '0; b2.ready_in = 1'b0; b2.get = 1'b0;
    b2.msb_first = 1'b1; b2.clr_err = 1'b0;
    nreset = 1'b0;
    repeat (3) tick();
    chk("reset_ready", 32'(b1.ready), 32'd0);
    chk("reset_byte", 32'(b1.byte_out), 32'd0);
    chk("reset_level", 32'(b1.byte_level), 32'd0);
    chk("reset_ovf", 32'(b1.errore_overflow), 32'd0);
    chk("reset_unf", 32'(b1.errore_underflow), 32'd0);
    nreset = 1'b1;
    tick();

    // Table: order, latching of msb_first, en freeze, underflow and clear priority
    b1.word_in = 16'hA55A;
    for (int i = 0; i < 20; i++) begin
      b1.en = tbl[i].en; b1.ready_in = tbl[i].rin; b1.get = tbl[i].get;
      b1.msb_first = tbl[i].msb; b1.clr_err = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_ready", i), 32'(b1.ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_byte", i), 32'(b1.byte_out), 32'(tbl[i].e_byte));
      chk($sformatf("vec%0d_level", i), 32'(b1.byte_level), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d_ovf", i), 32'(b1.errore_overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_unf", i), 32'(b1.errore_underflow), 32'(tbl[i].e_unf));
    end
    b1.en = 1'b1; b1.get = 1'b0; b1.clr_err = 1'b0; b1.msb_first = 1'b1;
    tick();

    // Overflow: 17 words into a 16-deep FIFO, drain, then clear
    for (int i = 0; i < 17; i++) strobe1(16'(i));
    chk("ovf_level", 32'(b1.byte_level), 32'd32);
    chk("ovf_flag", 32'(b1.errore_overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      get_byte1($sformatf("ovf_drain%0d_hi", i), 8'h00);
      get_byte1($sformatf("ovf_drain%0d_lo", i), 8'(i));
    end
    chk("ovf_drained_level", 32'(b1.byte_level), 32'd0);
    chk("ovf_drain_unf", 32'(b1.errore_underflow), 32'd0);
    b1.clr_err = 1'b1;
    tick();
    b1.clr_err = 1'b0;
    chk("ovf_cleared", 32'(b1.errore_overflow), 32'd0);

    // Full FIFO with push coinciding with last-slice pop, across pointer wrap
    for (int i = 0; i < 16; i++) strobe1(16'h5000 + 16'(i) * 16'h0011);
    chk("full_level", 32'(b1.byte_level), 32'd32);
    b1.word_in = 16'hBEEF;
    b1.ready_in = 1'b1; b1.get = 1'b1;
    tick();
    chk("coin_b0_ready", 32'(b1.ready), 32'd1);
    chk("coin_b0_byte", 32'(b1.byte_out), 32'h50);
    b1.get = 1'b0;
    tick();
    b1.ready_in = 1'b0; b1.get = 1'b1;
    tick();
    chk("coin_b1_byte", 32'(b1.byte_out), 32'h00);
    chk("coin_level", 32'(b1.byte_level), 32'd32);
    chk("coin_ovf", 32'(b1.errore_overflow), 32'd0);
    b1.get = 1'b0;
    repeat (3) tick();
    for (int k = 1; k < 17; k++) begin
      w = (k == 16) ? 16'hBEEF : 16'h5000 + 16'(k) * 16'h0011;
      get_byte1($sformatf("wrap%0d_hi", k), w[15:8]);
      get_byte1($sformatf("wrap%0d_lo", k), w[7:0]);
    end
    chk("wrap_level", 32'(b1.byte_level), 32'd0);
    chk("wrap_ovf", 32'(b1.errore_overflow), 32'd0);

    // Wider build: four slices, MSB first
    w32 = 32'h11223344;
    b2.word_in = w32; b2.ready_in = 1'b1;
    tick(); tick();
    b2.ready_in = 1'b0;
    repeat (3) tick();
    chk("w32_level", 32'(b2.byte_level), 32'd4);
    for (int s = 0; s < 4; s++) begin
      b2.get = 1'b1;
      tick();
      chk($sformatf("w32_s%0d_ready", s), 32'(b2.ready), 32'd1);
      chk($sformatf("w32_s%0d_byte", s), 32'(b2.byte_out), 32'(w32[31-8*s -: 8]));
      b2.get = 1'b0;
      tick();
    end
    chk("w32_level_end", 32'(b2.byte_level), 32'd0);

    // Asynchronous reset mid-drain with ready high and a flag set
    b1.get = 1'b1;
    tick();
    chk("pre_unf", 32'(b1.errore_underflow), 32'd1);
    b1.get = 1'b0;
    strobe1(16'hBEEF);
    b1.get = 1'b1;
    tick();
    chk("pre_ready", 32'(b1.ready), 32'd1);
    chk("pre_byte", 32'(b1.byte_out), 32'hBE);
    b1.get = 1'b0;
    #3;
    nreset = 1'b0;
    #1;
    chk("arst_ready", 32'(b1.ready), 32'd0);
    chk("arst_byte", 32'(b1.byte_out), 32'd0);
    chk("arst_level", 32'(b1.byte_level), 32'd0);
    chk("arst_unf", 32'(b1.errore_underflow), 32'd0);
    chk("arst_ovf", 32'(b1.errore_overflow), 32'd0);
    #2;
    nreset = 1'b1;
    tick();
    b1.get = 1'b1;
    tick();
    chk("post_ready", 32'(b1.ready), 32'd0);
    chk("post_unf", 32'(b1.errore_underflow), 32'd1);
    chk("post_level", 32'(b1.byte_level), 32'd0);
    chk("post_byte", 32'(b1.byte_out), 32'd0);
    b1.get = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_splitter.md
Name: word_splitter

Overview:
- Parametrised successor to the capture word-to-byte cutter.
- Accepts M-bit words on an asynchronous strobe and buffers them in a DEPTH-word circular FIFO.
- Returns them as N-bit slices, one per get/ready handshake toward the UART/USB byte path.
- Adds over the previous generation:
  - arbitrary ratio K = M/N
  - selectable slice order
  - occupancy reporting
  - sticky overflow and underflow flags with software clear

Parameters:
M, 16, input word width; must be a multiple of N
N, 8, output byte width
DEPTH, 16, word FIFO depth; power of two, at least 2
PTR_W, 4, log2(DEPTH)
LVL_W, 6, width of byte_level; must hold DEPTH*M/N

Ports:
rdclk  input  1  system clock; all logic on its rising edge
nreset  input  1  asynchronous active-low reset
en  input  1  block enable; 0 freezes FIFO, serializer and outputs
word_in  input  M  captured word; stable while ready_in is high
ready_in  input  1  asynchronous word strobe (rising edge = new word)
get  input  1  byte request from the consumer
msb_first  input  1  1: upper slice emitted first; 0: lower slice first
clr_err  input  1  synchronous clear of both error flags
byte_out  output  N  current byte
ready  output  1  one-cycle pulse marking byte_out valid
byte_level  output  LVL_W  bytes still available
errore_overflow  output  1  sticky: a word was dropped because the FIFO was full
errore_underflow  output  1  sticky: get arrived with no byte available

Behaviour:
- Reset (async, nreset=0):
  - byte_out=0, ready=0, byte_level=0, both error flags 0.
  - FIFO pointers, word count, slice index and synchroniser all cleared.
  - Reset mid-transfer discards all buffered data.
  - FIFO storage contents need not be cleared.
- Strobe input:
  - ready_in passes a 2-flop synchroniser.
  - A push event is a synchronised 0->1 transition; exactly one push per strobe pulse, however long the pulse.
  - The synchroniser runs regardless of en.
- Push (en=1, push event):
  - word_in is sampled on the cycle the edge is detected; it is written at wr_ptr, wr_ptr increments and count increments.
  - If count==DEPTH and no pop occurs that cycle: word dropped, errore_overflow<=1, pointers unchanged.
  - If count==DEPTH and a pop occurs the same cycle: push accepted, count stays DEPTH.
  - With en=0, push events are dropped silently; no overflow flag.
- Slice order:
  - Slice s (0..K-1) of the head word is word[M-1-s*N -: N] when msb_first=1, word[s*N +: N] when msb_first=0.
  - msb_first is latched when slice 0 of a word is emitted and held for the remaining slices of that word.
- Get handshake (en=1):
  - If ready=1: ready<=0 and get is ignored, so the minimum spacing is 2 cycles per byte.
  - Otherwise, if get=1 and byte_level>0:
    - byte_out<=slice(slice_idx), ready<=1 on the next edge (latency 1 cycle).
    - slice_idx increments.
    - At slice_idx==K-1: slice_idx<=0, rd_ptr increments, count decrements (pop).
  - Otherwise, if get=1 and byte_level==0: ready stays 0, byte_out holds, errore_underflow<=1.
  - byte_out holds its value between grants.
- Occupancy:
  - byte_level = count*K - slice_idx, registered, updated the cycle after any push or pop.
  - It never wraps: overflowed pushes are not counted, and underflow does not decrement.
- Simultaneous push and pop: both are applied; count is unchanged.
- Pointer wrap-around: modulo DEPTH, with no bubble at the wrap.
- Error flags:
  - clr_err=1 clears both flags.
  - If a set condition occurs in the same cycle as clr_err, set wins.
  - Flags update even with en=0 only through clr_err.
- en=0: all state holds, including a pending ready=1, which is cleared on the first enabled cycle.

Test Plan:
- Reset then single strobe with word_in=16'hA55A, msb_first=1, get pulsed twice -> ready pulses with byte_out=8'hA5 then 8'h5A; byte_level goes 2 -> 1 -> 0.
- Same word with msb_first=0 -> byte_out 8'h5A then 8'hA5; toggle msb_first between the two gets -> order unchanged within the word.
- 17 strobes with words 0x0000..0x0010, no gets -> byte_level=32, errore_overflow=1; drain 32 bytes -> words 0x0000..0x000F in order, word 0x0010 absent; clr_err -> flag 0.
- get with empty FIFO -> no ready pulse, errore_underflow=1; clr_err and get asserted together with the FIFO still empty -> flag remains 1.
- Push coinciding with the last-slice pop while full (count=16) -> count stays 16, no overflow, data order preserved across pointer wrap; M=32, N=8 build with word 32'h11223344, msb_first=1 -> bytes 11, 22, 33, 44.
- nreset asserted asynchronously mid-drain with ready=1 -> ready, byte_out, byte_level and flags 0 immediately; a subsequent get -> underflow, no stale bytes.
